conv_layer_scheduler: RTL and testbench

- Sequences one full 3x3 convolution pass over an IMAGE_SIZE x IMAGE_SIZE single-channel image.
- Drives the input interface (row load handshake), the weight cache (weight index), the kernel array (MAC enable, column select, accumulator clear) and the output interface (valid/ready per output row).
- Replaces the free-running stage sequencing in the current conv layer with an explicit tile/row scheduler that tolerates load and output backpressure.

---
 rtl/conv_layer_scheduler_if.sv | 32 +++
 rtl/conv_layer_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_conv_layer_scheduler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_scheduler_if.sv
// Control bus between the conv layer scheduler and its datapath/host partners:
// pass control, row-load handshake, kernel array controls and output row handshake.
interface conv_layer_scheduler_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              row_load_req;
    logic [ADDR_W-1:0] row_load_addr;
    logic              row_load_ack;
    logic [3:0]        weight_idx;
    logic [1:0]        col_sel;
    logic              mac_en;
    logic              acc_clr;
    logic              out_valid;
    logic [2:0]        out_row;
    logic              out_ready;

    modport master (
        input  start, abort, row_load_ack, out_ready,
        output busy, done, row_load_req, row_load_addr, weight_idx,
               col_sel, mac_en, acc_clr, out_valid, out_row
    );

    modport slave (
        output start, abort, row_load_ack, out_ready,
        input  busy, done, row_load_req, row_load_addr, weight_idx,
               col_sel, mac_en, acc_clr, out_valid, out_row
    );
endinterface

// File: rtl/conv_layer_scheduler.sv
// Row/tile scheduler for one 3x3 convolution pass: loads kernel rows, steps the
// kernel columns through the MAC array, drains the pipeline and hands out rows.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | requesting pixel row (out_row+krow), held until ack
// COMPUTE | KERNEL_SIZE MAC cycles, one per kernel column
// DRAIN   | MAC_LAT cycles for the array pipeline to settle
// OUTPUT  | presenting out_row results until out_ready
// DONE    | one-cycle completion pulse
module conv_layer_scheduler #(
    parameter int IMAGE_SIZE  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int ARRAY_SIZE  = 6,
    parameter int MAC_LAT     = 4,
    parameter int ADDR_W      = 8
) (
    input logic                    clk,
    input logic                    rst,
    conv_layer_scheduler_if.master sif
);
    localparam int KW = 2;
    localparam int RW = 3;
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [KW-1:0] K_LAST     = KW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ARRAY_SIZE - 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     out_row_q, out_row_d;
    logic [KW-1:0]     krow_q, krow_d;
    logic [KW-1:0]     kcol_q, kcol_d;
    logic [DW-1:0]     drain_q, drain_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              row_load_req_q, row_load_req_d;
    logic [ADDR_W-1:0] row_load_addr_q, row_load_addr_d;
    logic [3:0]        weight_idx_q, weight_idx_d;
    logic [1:0]        col_sel_q, col_sel_d;
    logic              mac_en_q, mac_en_d;
    logic              acc_clr_q, acc_clr_d;
    logic              out_valid_q, out_valid_d;

    always_comb begin
        state_d   = state_q;
        out_row_d = out_row_q;
        krow_d    = krow_q;
        kcol_d    = kcol_q;
        drain_d   = drain_q;

        unique case (state_q)
            S_IDLE: begin
                if (sif.start) begin
                    state_d   = S_LOAD;
                    out_row_d = '0;
                    krow_d    = '0;
                end
            end
            S_LOAD: begin
                if (sif.row_load_ack) begin
                    state_d = S_COMPUTE;
                    kcol_d  = '0;
                end
            end
            S_COMPUTE: begin
                if (kcol_q != K_LAST) begin
                    kcol_d = kcol_q + 1'b1;
                end else if (krow_q != K_LAST) begin
                    krow_d  = krow_q + 1'b1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_OUTPUT;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            S_OUTPUT: begin
                if (sif.out_ready) begin
                    if (out_row_q == ROW_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        out_row_d = out_row_q + 1'b1;
                        krow_d    = '0;
                        state_d   = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        busy_d          = (state_d != S_IDLE);
        done_d          = (state_d == S_DONE);
        row_load_req_d  = (state_d == S_LOAD);
        mac_en_d        = (state_d == S_COMPUTE);
        out_valid_d     = (state_d == S_OUTPUT);
        acc_clr_d       = (state_d == S_LOAD) && (state_q != S_LOAD) && (krow_d == '0);
        row_load_addr_d = row_load_addr_q;
        weight_idx_d    = weight_idx_q;
        col_sel_d       = col_sel_q;

        if (state_d == S_LOAD) begin
            row_load_addr_d = ADDR_W'((int'(out_row_d) + int'(krow_d)) * IMAGE_SIZE);
        end
        if (state_d == S_COMPUTE) begin
            col_sel_d    = kcol_d;
            weight_idx_d = 4'(int'(krow_d) * KERNEL_SIZE + int'(kcol_d));
        end

        // Abort drops everything, including held index/address values.
        if (sif.abort) begin
            state_d         = S_IDLE;
            out_row_d       = '0;
            krow_d          = '0;
            kcol_d          = '0;
            drain_d         = '0;
            busy_d          = 1'b0;
            done_d          = 1'b0;
            row_load_req_d  = 1'b0;
            row_load_addr_d = '0;
            weight_idx_d    = '0;
            col_sel_d       = '0;
            mac_en_d        = 1'b0;
            acc_clr_d       = 1'b0;
            out_valid_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            out_row_q       <= '0;
            krow_q          <= '0;
            kcol_q          <= '0;
            drain_q         <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            row_load_req_q  <= 1'b0;
            row_load_addr_q <= '0;
            weight_idx_q    <= '0;
            col_sel_q       <= '0;
            mac_en_q        <= 1'b0;
            acc_clr_q       <= 1'b0;
            out_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            out_row_q       <= out_row_d;
            krow_q          <= krow_d;
            kcol_q          <= kcol_d;
            drain_q         <= drain_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            row_load_req_q  <= row_load_req_d;
            row_load_addr_q <= row_load_addr_d;
            weight_idx_q    <= weight_idx_d;
            col_sel_q       <= col_sel_d;
            mac_en_q        <= mac_en_d;
            acc_clr_q       <= acc_clr_d;
            out_valid_q     <= out_valid_d;
        end
    end

    assign sif.busy          = busy_q;
    assign sif.done          = done_q;
    assign sif.row_load_req  = row_load_req_q;
    assign sif.row_load_addr = row_load_addr_q;
    assign sif.weight_idx    = weight_idx_q;
    assign sif.col_sel       = col_sel_q;
    assign sif.mac_en        = mac_en_q;
    assign sif.acc_clr       = acc_clr_q;
    assign sif.out_valid     = out_valid_q;
    assign sif.out_row       = out_row_q;
endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler: full passes with and without
// backpressure, busy-start, abort, late ack and reset mid-pass.
module tb_conv_layer_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;

    conv_layer_scheduler_if #(.ADDR_W(8)) bus ();

    conv_layer_scheduler dut (
        .clk (clk),
        .rst (rst),
        .sif (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int busy_first, busy_last, busy_cnt;
    int done_cnt, done_cyc;
    int mac_cnt, widx_err, col_err;
    int ld_cnt, addr_err;
    int hs_cnt, row_err;
    int acc_cnt, acc_err;
    int stab_err, vstab_err, ovl_err;
    logic [22:0] snap_abort;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [22:0] snap();
        return {bus.busy, bus.done, bus.row_load_req, bus.row_load_addr, bus.weight_idx,
                bus.col_sel, bus.mac_en, bus.acc_clr, bus.out_valid, bus.out_row};
    endfunction

    // Start in cycle 0, then observe/drive n_cyc cycles at the falling edge.
    task automatic run_pass(input int ack_d, input int hold_row, input int hold_n,
                            input int abort_at, input int st_a, input int st_b,
                            input int n_cyc);
        int req_age, val_age;
        logic p_req, p_ack, p_val, p_rdy;
        logic [7:0] p_addr;
        logic [2:0] p_row;
        busy_first = -1; busy_last = -1; busy_cnt = 0;
        done_cnt = 0; done_cyc = -1;
        mac_cnt = 0; widx_err = 0; col_err = 0;
        ld_cnt = 0; addr_err = 0; hs_cnt = 0; row_err = 0;
        acc_cnt = 0; acc_err = 0; stab_err = 0; vstab_err = 0; ovl_err = 0;
        snap_abort = '1;
        req_age = 0; val_age = 0;
        p_req = 1'b0; p_ack = 1'b0; p_val = 1'b0; p_rdy = 1'b0;
        p_addr = '0; p_row = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b0; bus.row_load_ack = 1'b0; bus.out_ready = 1'b1;
        for (int c = 1; c <= n_cyc; c++) begin
            @(negedge clk);
            bus.start = (c == st_a) || (c == st_b);
            bus.abort = (c == abort_at);
            req_age = bus.row_load_req ? req_age + 1 : 0;
            bus.row_load_ack = bus.row_load_req && (req_age > ack_d);
            val_age = bus.out_valid ? val_age + 1 : 0;
            bus.out_ready = !(bus.out_valid && int'(bus.out_row) == hold_row && val_age <= hold_n);

            if (p_req && !p_ack && !(bus.row_load_req && bus.row_load_addr == p_addr)) stab_err++;
            if (p_val && !p_rdy && !(bus.out_valid && bus.out_row == p_row)) vstab_err++;
            if (bus.mac_en && bus.row_load_req) ovl_err++;
            if (bus.out_valid && bus.row_load_req) ovl_err++;
            if (bus.acc_clr) begin
                acc_cnt++;
                if (!bus.row_load_req) acc_err++;
            end
            if (bus.busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
                busy_cnt++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (bus.mac_en) begin
                if (int'(bus.weight_idx) != mac_cnt % 9) widx_err++;
                if (int'(bus.col_sel) != mac_cnt % 3) col_err++;
                mac_cnt++;
            end
            if (bus.row_load_req && bus.row_load_ack) begin
                if (int'(bus.row_load_addr) != ((ld_cnt / 3) + (ld_cnt % 3)) * 8) addr_err++;
                ld_cnt++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (int'(bus.out_row) != hs_cnt) row_err++;
                hs_cnt++;
            end
            if (c == abort_at + 1) snap_abort = snap();

            p_req = bus.row_load_req; p_ack = bus.row_load_ack; p_addr = bus.row_load_addr;
            p_val = bus.out_valid; p_rdy = bus.out_ready; p_row = bus.out_row;
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.row_load_ack = 1'b0; bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.row_load_ack = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'(snap()), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", int'(snap()), 0);

        // zero-wait pass
        run_pass(0, -1, 0, -1, -1, -1, 106);
        check("zw_busy_first", busy_first, 1);
        check("zw_busy_last", busy_last, 103);
        check("zw_busy_cnt", busy_cnt, 103);
        check("zw_done_cyc", done_cyc, 103);
        check("zw_done_cnt", done_cnt, 1);
        check("zw_out_rows", hs_cnt, 6);
        check("zw_out_row_seq", row_err, 0);
        check("zw_mac_cnt", mac_cnt, 54);
        check("zw_widx_seq", widx_err, 0);
        check("zw_col_seq", col_err, 0);
        check("zw_loads", ld_cnt, 18);
        check("zw_load_addr", addr_err, 0);
        check("zw_acc_clr_cnt", acc_cnt, 6);
        check("zw_acc_clr_in_load", acc_err, 0);
        check("zw_widx_hold", int'(bus.weight_idx), 8);
        check("zw_col_hold", int'(bus.col_sel), 2);

        // load backpressure: every ack delayed 5 cycles
        run_pass(5, -1, 0, -1, -1, -1, 200);
        check("lbp_done_cyc", done_cyc, 193);
        check("lbp_done_cnt", done_cnt, 1);
        check("lbp_req_stable", stab_err, 0);
        check("lbp_no_overlap", ovl_err, 0);
        check("lbp_loads", ld_cnt, 18);
        check("lbp_load_addr", addr_err, 0);
        check("lbp_mac_cnt", mac_cnt, 54);

        // output backpressure: ready low 10 cycles on row 2
        run_pass(0, 2, 10, -1, -1, -1, 120);
        check("obp_done_cyc", done_cyc, 113);
        check("obp_valid_stable", vstab_err, 0);
        check("obp_no_overlap", ovl_err, 0);
        check("obp_out_rows", hs_cnt, 6);
        check("obp_out_row_seq", row_err, 0);

        // start while busy is ignored
        run_pass(0, -1, 0, -1, 20, 50, 106);
        check("sb_done_cyc", done_cyc, 103);
        check("sb_done_cnt", done_cnt, 1);
        check("sb_busy_last", busy_last, 103);

        // abort in the second COMPUTE cycle of out_row 3
        run_pass(0, -1, 0, 54, -1, -1, 60);
        check("ab_outputs_zero", int'(snap_abort), 0);
        check("ab_busy_last", busy_last, 54);
        check("ab_no_done", done_cnt, 0);
        check("ab_rows_before", hs_cnt, 3);

        // late ack after abort
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.row_load_ack = 1'b1;
        end
        @(negedge clk);
        bus.row_load_ack = 1'b0;
        check("late_ack_ignored", int'(snap()), 0);

        // start and abort together in IDLE
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start_abort_idle", int'(snap()), 0);

        // fresh pass after abort
        run_pass(0, -1, 0, -1, -1, -1, 106);
        check("re_done_cyc", done_cyc, 103);
        check("re_out_rows", hs_cnt, 6);
        check("re_load_addr", addr_err, 0);
        check("re_widx_seq", widx_err, 0);

        // reset mid-pass
        run_pass(0, -1, 0, -1, -1, -1, 30);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_zero", int'(snap()), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", int'(snap()), 0);
        run_pass(0, -1, 0, -1, -1, -1, 106);
        check("pr_done_cyc", done_cyc, 103);
        check("pr_out_row_seq", row_err, 0);
        check("pr_mac_cnt", mac_cnt, 54);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
